// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared types and encodings for the multicycle control path:
//               sequencer states, instruction fields, ALU/mux select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Sequencer states; the numeric value is what state_o reports.
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    // Instruction op field
    localparam logic [1:0] c_op_dp  = 2'b00;
    localparam logic [1:0] c_op_mem = 2'b01;
    localparam logic [1:0] c_op_br  = 2'b10;
    localparam logic [1:0] c_op_ill = 2'b11;

    // Data-processing cmd field (Funct[4:1])
    localparam logic [3:0] c_cmd_and = 4'b0000;
    localparam logic [3:0] c_cmd_sub = 4'b0010;
    localparam logic [3:0] c_cmd_add = 4'b0100;
    localparam logic [3:0] c_cmd_cmp = 4'b1010;
    localparam logic [3:0] c_cmd_orr = 4'b1100;

    // ALUControl codes
    localparam logic [1:0] c_alu_add = 2'b00;
    localparam logic [1:0] c_alu_sub = 2'b01;
    localparam logic [1:0] c_alu_and = 2'b10;
    localparam logic [1:0] c_alu_orr = 2'b11;

    // ResultSrc codes
    localparam logic [1:0] c_res_aluout = 2'b00;
    localparam logic [1:0] c_res_rddata = 2'b01;
    localparam logic [1:0] c_res_alu    = 2'b10;

    // ALUSrcB codes
    localparam logic [1:0] c_srcb_rm   = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

    // Register index of the program counter
    localparam logic [3:0] c_pc_idx = 4'hF;

    // States that stall on the memory handshake and feed the timeout counter.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_fsm_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps the data-processing cmd/S bits and the current sequencer
//               state to ALUControl, flag-write enables and a CMP indicator.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import cpu_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [3:0] i_cmd,
    input  logic       i_s,
    output logic [1:0] o_alu_control,
    output logic [1:0] o_flag_w,
    output logic       o_is_cmp,
    output logic       o_cmd_valid
);

    logic [1:0] w_alu_op;
    logic       w_dp_state;
    logic       w_flag_en;

    // Translate cmd into an ALU operation; unknown cmds fall back to ADD and
    // are flagged invalid so the sequencer suppresses their side effects.
    always_comb begin
        w_alu_op    = c_alu_add;
        o_cmd_valid = 1'b1;
        o_is_cmp    = 1'b0;
        case (i_cmd)
            c_cmd_add: w_alu_op = c_alu_add;
            c_cmd_sub: w_alu_op = c_alu_sub;
            c_cmd_and: w_alu_op = c_alu_and;
            c_cmd_orr: w_alu_op = c_alu_orr;
            c_cmd_cmp: begin
                w_alu_op = c_alu_sub;
                o_is_cmp = 1'b1;
            end
            default: begin
                w_alu_op    = c_alu_add;
                o_cmd_valid = 1'b0;
            end
        endcase
    end

    // Only the data-processing states use the decoded op; flags only update
    // in the writeback step, and C/V only for arithmetic ops.
    always_comb begin
        w_dp_state    = (i_state == EXECR) || (i_state == EXECI) || (i_state == ALUWB);
        o_alu_control = w_dp_state ? w_alu_op : c_alu_add;
        w_flag_en     = (i_state == ALUWB) && o_cmd_valid && (i_s || o_is_cmp);
        o_flag_w[1]   = w_flag_en;
        o_flag_w[0]   = w_flag_en && ((w_alu_op == c_alu_add) || (w_alu_op == c_alu_sub));
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Main sequencer of the multicycle core. Walks fetch, decode,
//               execute, memory and writeback, waits on mem_ready, produces
//               unconditioned strobes, datapath selects and a sticky timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W    = 2,
    parameter int FUNCT_W = 6,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    Op,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic [3:0]         Rd,
    input  logic               mem_ready,
    output logic               PCS,
    output logic               RegW,
    output logic               MemW,
    output logic [1:0]         FlagW,
    output logic               NextPC,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic               mem_err,
    output logic [3:0]         state_o
);

    // Last count value before the timeout fires (counter is 8 bits wide).
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mem_err_q, mem_err_d;

    logic [1:0] w_alu_control;
    logic [1:0] w_flag_w;
    logic       w_is_cmp;
    logic       w_cmd_valid;
    logic       w_dp_regw;

    alu_decoder u_alu_decoder (
        .i_state       (state_q),
        .i_cmd         (Funct[4:1]),
        .i_s           (Funct[0]),
        .o_alu_control (w_alu_control),
        .o_flag_w      (w_flag_w),
        .o_is_cmp      (w_is_cmp),
        .o_cmd_valid   (w_cmd_valid)
    );

    // Next-state, wait counter and sticky error; a timeout overrides the
    // normal transition but only when mem_ready did not arrive this cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        mem_err_d = mem_err_q;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (Op)
                    c_op_dp:  state_d = Funct[5] ? EXECI : EXECR;
                    c_op_mem: state_d = MEMADR;
                    c_op_br:  state_d = BRANCH;
                    c_op_ill: state_d = FETCH;
                    default:  state_d = FETCH;
                endcase
            end
            MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (mem_ready) state_d = FETCH;
            EXECR:  state_d = ALUWB;
            EXECI:  state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            default: state_d = FETCH;
        endcase

        if (is_wait_state(state_q) && !mem_ready) begin
            if (cnt_q == c_timeout_last) begin
                mem_err_d = 1'b1;
                state_d   = FETCH;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State, counter and error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Per-state strobes and selects; everything is forced low while rst is
    // high so an abandoned instruction never leaks a write.
    always_comb begin
        PCS        = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        FlagW      = 2'b00;
        NextPC     = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = c_res_aluout;
        ALUSrcA    = 1'b0;
        ALUSrcB    = c_srcb_rm;
        ALUControl = c_alu_add;
        w_dp_regw  = w_cmd_valid && !w_is_cmp;
        if (!rst) begin
            ALUControl = w_alu_control;
            FlagW      = w_flag_w;
            case (state_q)
                FETCH: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = c_srcb_four;
                    ResultSrc = c_res_alu;
                    IRWrite   = mem_ready;
                    NextPC    = mem_ready;
                end
                DECODE: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = c_srcb_four;
                    ResultSrc = c_res_alu;
                end
                MEMADR: ALUSrcB = c_srcb_imm;
                MEMRD:  AdrSrc  = 1'b1;
                MEMWB: begin
                    ResultSrc = c_res_rddata;
                    RegW      = 1'b1;
                    PCS       = (Rd == c_pc_idx);
                end
                MEMWR: begin
                    AdrSrc = 1'b1;
                    MemW   = 1'b1;
                end
                EXECR: ALUSrcB = c_srcb_rm;
                EXECI: ALUSrcB = c_srcb_imm;
                ALUWB: begin
                    ResultSrc = c_res_aluout;
                    RegW      = w_dp_regw;
                    PCS       = w_dp_regw && (Rd == c_pc_idx);
                end
                BRANCH: begin
                    ALUSrcB   = c_srcb_imm;
                    ResultSrc = c_res_alu;
                    PCS       = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_err = mem_err_q;
    assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Self-checking bench: an instruction-plan model checked every
//               cycle, plus directed instruction sequences with literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic [3:0] Rd = 4'h0;
    logic       mem_ready = 1'b0;
    logic       PCS, RegW, MemW, NextPC, IRWrite, AdrSrc, ALUSrcA, mem_err;
    logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl;
    logic [3:0] state_o;

    logic [1:0] ir_op = 2'b00;
    logic [5:0] ir_funct = 6'b0;
    logic [3:0] ir_rd = 4'h0;

    int total = 0;
    int bad = 0;

    // Model: current step, remaining steps of the instruction, wait count.
    state_t m_state = FETCH;
    state_t m_plan[$];
    int     m_wait = 0;
    logic   m_err = 1'b0;

    multicycle_control_fsm #(.OP_W(2), .FUNCT_W(6), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Rd(Rd), .mem_ready(mem_ready),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW), .NextPC(NextPC),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .mem_err(mem_err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void cmd_info(input logic [3:0] cmd, output logic [1:0] alu,
                                     output logic ok, output logic cmp);
        ok = 1'b1; cmp = 1'b0; alu = 2'b00;
        case (cmd)
            4'b0100: alu = 2'b00;
            4'b0010: alu = 2'b01;
            4'b0000: alu = 2'b10;
            4'b1100: alu = 2'b11;
            4'b1010: begin alu = 2'b01; cmp = 1'b1; end
            default: ok = 1'b0;
        endcase
    endfunction

    // Model advance: the instruction's step list is laid out at DECODE and
    // consumed one step per cycle; fetch/memory steps hold until mem_ready.
    always @(posedge clk) begin
        if (rst) begin
            m_state = FETCH; m_wait = 0; m_err = 1'b0; m_plan.delete();
        end else if ((m_state == FETCH || m_state == MEMRD || m_state == MEMWR) && !mem_ready) begin
            m_wait++;
            if (m_wait == 255) begin
                m_err = 1'b1; m_wait = 0; m_plan.delete(); m_state = FETCH;
            end
        end else begin
            m_wait = 0;
            if (m_state == FETCH) begin
                m_state = DECODE;
            end else begin
                if (m_state == DECODE) begin
                    m_plan.delete();
                    case (Op)
                        2'b00: begin m_plan.push_back(Funct[5] ? EXECI : EXECR); m_plan.push_back(ALUWB); end
                        2'b01: begin
                            m_plan.push_back(MEMADR);
                            m_plan.push_back(Funct[0] ? MEMRD : MEMWR);
                            if (Funct[0]) m_plan.push_back(MEMWB);
                        end
                        2'b10: m_plan.push_back(BRANCH);
                        default: ;
                    endcase
                end
                m_state = (m_plan.size() > 0) ? m_plan.pop_front() : FETCH;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic e_pcs, e_regw, e_memw, e_npc, e_irw, e_adr, e_srca, ok, cmp;
        logic [1:0] e_fw, e_res, e_srcb, e_alu, c_alu;
        cmd_info(Funct[4:1], c_alu, ok, cmp);
        e_pcs = 0; e_regw = 0; e_memw = 0; e_npc = 0; e_irw = 0; e_adr = 0; e_srca = 0;
        e_fw = 0; e_res = 0; e_srcb = 0; e_alu = 0;
        if (!rst) begin
            case (m_state)
                FETCH:  begin e_srca = 1; e_srcb = 2; e_res = 2; e_irw = mem_ready; e_npc = mem_ready; end
                DECODE: begin e_srca = 1; e_srcb = 2; e_res = 2; end
                MEMADR: e_srcb = 1;
                MEMRD:  e_adr = 1;
                MEMWB:  begin e_res = 1; e_regw = 1; e_pcs = (Rd == 4'hF); end
                MEMWR:  begin e_adr = 1; e_memw = 1; end
                EXECR:  e_alu = c_alu;
                EXECI:  begin e_srcb = 1; e_alu = c_alu; end
                ALUWB: begin
                    e_alu = c_alu;
                    e_regw = ok && !cmp;
                    e_pcs = e_regw && (Rd == 4'hF);
                    if (ok && (Funct[0] || cmp)) e_fw = {1'b1, (c_alu == 2'b00 || c_alu == 2'b01)};
                end
                BRANCH: begin e_srcb = 1; e_res = 2; e_pcs = 1; end
                default: ;
            endcase
        end
        chk("m_state", state_o, m_state);
        chk("m_mem_err", mem_err, m_err);
        chk("m_PCS", PCS, e_pcs);
        chk("m_RegW", RegW, e_regw);
        chk("m_MemW", MemW, e_memw);
        chk("m_FlagW", FlagW, e_fw);
        chk("m_NextPC", NextPC, e_npc);
        chk("m_IRWrite", IRWrite, e_irw);
        chk("m_AdrSrc", AdrSrc, e_adr);
        chk("m_ResultSrc", ResultSrc, e_res);
        chk("m_ALUSrcA", ALUSrcA, e_srca);
        chk("m_ALUSrcB", ALUSrcB, e_srcb);
        chk("m_ALUControl", ALUControl, e_alu);
    end

    // One clock cycle: inputs change just after the edge, return at negedge.
    task automatic cyc(input logic rdy, input logic r = 1'b0);
        @(posedge clk); #1;
        rst = r; mem_ready = rdy; Op = ir_op; Funct = ir_funct; Rd = ir_rd;
        @(negedge clk);
    endtask

    task automatic run_dp(input logic [5:0] f, input logic [3:0] rd, input logic e_regw,
                          input logic [1:0] e_fw, input logic [1:0] e_alu, input logic e_pcs);
        ir_op = 2'b00; ir_funct = f; ir_rd = rd;
        cyc(1); chk("dp_fetch_irwrite", IRWrite, 1);
        cyc(1); chk("dp_decode", state_o, DECODE);
        cyc(1); chk("dp_exec_state", state_o, f[5] ? EXECI : EXECR);
                chk("dp_exec_alu", ALUControl, e_alu);
        cyc(1); chk("dp_wb_state", state_o, ALUWB);
                chk("dp_wb_regw", RegW, e_regw);
                chk("dp_wb_flagw", FlagW, e_fw);
                chk("dp_wb_alu", ALUControl, e_alu);
                chk("dp_wb_pcs", PCS, e_pcs);
        cyc(0); chk("dp_back_fetch", state_o, FETCH);
    endtask

    initial begin
        cyc(0, 1); cyc(0, 1);
        chk("rst_regw", RegW, 0); chk("rst_irwrite", IRWrite, 0); chk("rst_srca", ALUSrcA, 0);
        cyc(0);
        chk("reset_state", state_o, FETCH); chk("reset_err", mem_err, 0); chk("reset_srcb", ALUSrcB, 2);

        run_dp(6'b001001, 4'h3, 1, 2'b11, 2'b00, 0); // ADDS
        run_dp(6'b110101, 4'h3, 0, 2'b11, 2'b01, 0); // CMP imm
        run_dp(6'b011001, 4'h5, 1, 2'b10, 2'b11, 0); // ORRS
        run_dp(6'b000100, 4'hF, 1, 2'b00, 2'b01, 1); // SUB to PC
        run_dp(6'b000011, 4'h4, 0, 2'b00, 2'b00, 0); // unknown cmd
        run_dp(6'b100000, 4'h2, 1, 2'b00, 2'b10, 0); // AND imm

        // Load to PC with three stall cycles in MEMRD: 8 cycles total
        ir_op = 2'b01; ir_funct = 6'b000001; ir_rd = 4'hF;
        cyc(1); cyc(1); cyc(1); chk("ld_memadr_srcb", ALUSrcB, 1);
        cyc(0); chk("ld_memrd_adr", AdrSrc, 1);
        cyc(0); cyc(0);
        cyc(1); chk("ld_memrd_held", state_o, MEMRD);
        cyc(1); chk("ld_wb_state", state_o, MEMWB); chk("ld_wb_regw", RegW, 1);
                chk("ld_wb_pcs", PCS, 1); chk("ld_wb_res", ResultSrc, 1);
        cyc(0); chk("ld_back_fetch", state_o, FETCH);

        // Store with two stall cycles
        ir_op = 2'b01; ir_funct = 6'b000000; ir_rd = 4'h2;
        cyc(1); cyc(1); cyc(1);
        cyc(0); chk("st_state", state_o, MEMWR); chk("st_memw0", MemW, 1); chk("st_adr", AdrSrc, 1);
        cyc(0); chk("st_memw1", MemW, 1);
        cyc(1); chk("st_memw_ready", MemW, 1);
        cyc(0); chk("st_memw_off", MemW, 0); chk("st_back_fetch", state_o, FETCH);

        // Branch: 3 cycles
        ir_op = 2'b10; ir_funct = 6'b000000; ir_rd = 4'h0;
        cyc(1); cyc(1);
        cyc(1); chk("br_state", state_o, BRANCH); chk("br_pcs", PCS, 1);
                chk("br_srca", ALUSrcA, 0); chk("br_srcb", ALUSrcB, 1);
        cyc(0); chk("br_back_fetch", state_o, FETCH);

        // Illegal op returns to FETCH with no strobes
        ir_op = 2'b11;
        cyc(1); cyc(1); chk("ill_decode_regw", RegW, 0); chk("ill_decode_pcs", PCS, 0);
        cyc(0); chk("ill_back_fetch", state_o, FETCH);

        // Reset in the middle of a load
        ir_op = 2'b01; ir_funct = 6'b000001; ir_rd = 4'h2;
        cyc(1); cyc(1); cyc(1);
        cyc(0); chk("mid_memrd", state_o, MEMRD);
        cyc(0, 1); chk("mid_rst_adr", AdrSrc, 0); chk("mid_rst_regw", RegW, 0);
        cyc(0); chk("mid_after_state", state_o, FETCH); chk("mid_after_err", mem_err, 0);

        // mem_ready on the 255th waiting cycle beats the timeout
        ir_op = 2'b11;
        cyc(0, 1);
        repeat (254) cyc(0);
        cyc(1); chk("race_irwrite", IRWrite, 1);
        cyc(0); chk("race_decode", state_o, DECODE); chk("race_no_err", mem_err, 0);

        // Timeout after 255 waiting cycles in FETCH
        cyc(0, 1);
        repeat (254) cyc(0);
        cyc(0); chk("to_err_pending", mem_err, 0);
        cyc(0); chk("to_err_set", mem_err, 1); chk("to_state", state_o, FETCH);
        cyc(1); cyc(1); chk("to_err_sticky", mem_err, 1);
        cyc(0, 1);
        cyc(0); chk("to_err_cleared", mem_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
